// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: receives an SSD1306-style 4-wire SPI stream and splits it into
// frame-buffer writes (dc=1) and decoded command/parameter bytes (dc=0).
// Ports:
//   clk, rst_n              system clock, synchronous active-low reset
//   io_sclk, io_sdin        serial clock (idles high, sampled on rise) and MSB-first data
//   io_cs, io_dc, io_reset  chip select (low), data/command select, display reset (low)
//   fb_we, fb_addr, fb_data one-cycle frame-buffer write strobe, byte address, byte
//   cmd_valid, cmd_byte     one-cycle strobe per command or parameter byte
//   display_on, invert      flags driven by 0xAE/0xAF and 0xA6/0xA7
//   contrast, charge_pump   last 0x81 parameter, bit 2 of last 0x8D parameter
module oled_spi_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       io_sclk,
   input  logic       io_sdin,
   input  logic       io_cs,
   input  logic       io_dc,
   input  logic       io_reset,
   output logic       fb_we,
   output logic [9:0] fb_addr,
   output logic [7:0] fb_data,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       display_on,
   output logic       invert,
   output logic [7:0] contrast,
   output logic       charge_pump
);
   typedef enum logic {CMD_IDLE, CMD_PARAM} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, rst_sync;
   logic       sclk_d;
   logic       sclk_s, sdin_s, cs_s, dc_s, rst_s;
   logic       clear, shift_ev, byte_done, takes_param;
   logic [2:0] bit_cnt;
   logic [7:0] shreg, rx_byte, opcode, opcode_n, contrast_n;
   logic       display_on_n, invert_n, charge_pump_n;
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign sdin_s = sdin_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign dc_s   = dc_sync[SYNC_STAGES-1];
   assign rst_s  = rst_sync[SYNC_STAGES-1];
   // io_reset clears everything but the synchronizers, which must keep tracking the pins
   assign clear     = !rst_n || !rst_s;
   assign shift_ev  = sclk_s && !sclk_d && !cs_s;
   assign byte_done = shift_ev && bit_cnt == 3'd7;
   assign rx_byte   = {shreg[6:0], sdin_s};
   assign takes_param = rx_byte inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D};
   // sclk_d resets high so a released reset with sclk high never looks like an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync <= '1;
         sdin_sync <= '0;
         cs_sync   <= '1;
         dc_sync   <= '1;
         rst_sync  <= '1;
         sclk_d    <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_sclk};
         sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], io_sdin};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], io_cs};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], io_dc};
         rst_sync  <= {rst_sync[SYNC_STAGES-2:0], io_reset};
         sclk_d    <= sclk_s;
      end
   end
   // Byte assembler and output strobes; strobes land one cycle after the 8th edge
   always_ff @(posedge clk) begin
      if (clear) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         fb_we     <= 1'b0;
         cmd_valid <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
         cmd_byte  <= '0;
      end else begin
         if (cs_s)
            bit_cnt <= '0;
         else if (shift_ev) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= rx_byte;
         end
         fb_we     <= byte_done && dc_s;
         cmd_valid <= byte_done && !dc_s;
         fb_data   <= byte_done && dc_s ? rx_byte : fb_data;
         cmd_byte  <= byte_done && !dc_s ? rx_byte : cmd_byte;
         // address advances the cycle after the write so fb_addr is valid alongside fb_we
         fb_addr   <= fb_we ? fb_addr + 10'd1 : fb_addr;
      end
   end
   always_ff @(posedge clk) begin
      if (clear) begin
         state       <= CMD_IDLE;
         opcode      <= '0;
         display_on  <= 1'b0;
         invert      <= 1'b0;
         contrast    <= 8'h7F;
         charge_pump <= 1'b0;
      end else begin
         state       <= state_n;
         opcode      <= opcode_n;
         display_on  <= display_on_n;
         invert      <= invert_n;
         contrast    <= contrast_n;
         charge_pump <= charge_pump_n;
      end
   end
   // Command decoder; a data byte always drops a pending parameter
   always_comb begin
      state_n       = state;
      opcode_n      = opcode;
      display_on_n  = display_on;
      invert_n      = invert;
      contrast_n    = contrast;
      charge_pump_n = charge_pump;
      if (byte_done && dc_s)
         state_n = CMD_IDLE;
      else if (byte_done && state == CMD_PARAM) begin
         state_n       = CMD_IDLE;
         contrast_n    = opcode == 8'h81 ? rx_byte : contrast;
         charge_pump_n = opcode == 8'h8D ? rx_byte[2] : charge_pump;
      end else if (byte_done) begin
         display_on_n = rx_byte == 8'hAF ? 1'b1 : rx_byte == 8'hAE ? 1'b0 : display_on;
         invert_n     = rx_byte == 8'hA7 ? 1'b1 : rx_byte == 8'hA6 ? 1'b0 : invert;
         state_n      = takes_param ? CMD_PARAM : CMD_IDLE;
         opcode_n     = takes_param ? rx_byte : opcode;
      end
   end
endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver: directed and randomized SPI traffic checked against a byte-level model
module tb_oled_spi_receiver;
   logic       clk = 0, rst_n = 0;
   logic       io_sclk = 1, io_sdin = 0, io_cs = 1, io_dc = 1, io_reset = 1;
   logic       fb_we, cmd_valid, display_on, invert, charge_pump;
   logic [9:0] fb_addr;
   logic [7:0] fb_data, cmd_byte, contrast;
   int n_cmp = 0, n_err = 0, half = 4;
   int both_cnt = 0, long_cnt = 0;
   logic prev_we = 0, prev_cv = 0;
   logic [7:0]  exp_cmd[$], obs_cmd[$];
   logic [17:0] exp_fb[$], obs_fb[$];
   logic [9:0]  m_addr;
   logic [7:0]  m_op, m_con;
   bit          m_param, m_disp, m_inv, m_cp;
   logic [7:0]  init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                                  8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                  8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
   logic [7:0]  ops [10] = '{8'h81, 8'h8D, 8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'h20, 8'hA4, 8'hD5, 8'h40};

   oled_spi_receiver dut (
      .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
      .io_dc(io_dc), .io_reset(io_reset), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .display_on(display_on), .invert(invert), .contrast(contrast),
      .charge_pump(charge_pump));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fb_we) obs_fb.push_back({fb_addr, fb_data});
      if (cmd_valid) obs_cmd.push_back(cmd_byte);
      if (fb_we && cmd_valid) both_cnt++;
      if ((fb_we && prev_we) || (cmd_valid && prev_cv)) long_cnt++;
      prev_we = fb_we;
      prev_cv = cmd_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0; m_param = 0; m_op = 0; m_disp = 0; m_inv = 0; m_con = 8'h7F; m_cp = 0;
   endtask

   // Byte-level behaviour: data goes to the next address, commands follow the opcode rules
   task automatic model_byte(input logic [7:0] b, input bit d);
      if (d) begin
         exp_fb.push_back({m_addr, b});
         m_addr = m_addr + 10'd1;
         m_param = 0;
      end else begin
         exp_cmd.push_back(b);
         if (m_param) begin
            if (m_op == 8'h81) m_con = b;
            if (m_op == 8'h8D) m_cp = b[2];
            m_param = 0;
         end else begin
            if (b == 8'hAF) m_disp = 1;
            if (b == 8'hAE) m_disp = 0;
            if (b == 8'hA7) m_inv = 1;
            if (b == 8'hA6) m_inv = 0;
            if (b inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D}) begin
               m_param = 1;
               m_op = b;
            end
         end
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input bit d);
      io_cs = 0;
      for (int i = 0; i < n; i++) begin
         io_sclk = 0; io_sdin = b[7-i]; io_dc = d;
         repeat (half) @(negedge clk);
         io_sclk = 1;
         repeat (half) @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit d);
      send_bits(b, 8, d);
      model_byte(b, d);
   endtask

   task automatic check_all(input string tag);
      repeat (10) @(negedge clk);
      chk({tag, " cmd_count"}, obs_cmd.size(), exp_cmd.size());
      for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
         chk({tag, " cmd_byte"}, obs_cmd[i], exp_cmd[i]);
      chk({tag, " fb_count"}, obs_fb.size(), exp_fb.size());
      for (int i = 0; i < exp_fb.size() && i < obs_fb.size(); i++)
         chk({tag, " fb_addr_data"}, obs_fb[i], exp_fb[i]);
      obs_cmd.delete(); exp_cmd.delete(); obs_fb.delete(); exp_fb.delete();
      chk({tag, " display_on"}, display_on, m_disp);
      chk({tag, " invert"}, invert, m_inv);
      chk({tag, " contrast"}, contrast, m_con);
      chk({tag, " charge_pump"}, charge_pump, m_cp);
      chk({tag, " fb_addr"}, fb_addr, m_addr);
   endtask

   initial begin
      model_reset();
      repeat (4) @(negedge clk);
      chk("rst fb_we", fb_we, 0);
      chk("rst cmd_valid", cmd_valid, 0);
      chk("rst fb_addr", fb_addr, 0);
      chk("rst fb_data", fb_data, 0);
      chk("rst cmd_byte", cmd_byte, 0);
      chk("rst display_on", display_on, 0);
      chk("rst invert", invert, 0);
      chk("rst contrast", contrast, 8'h7F);
      chk("rst charge_pump", charge_pump, 0);
      rst_n = 1;
      repeat (4) @(negedge clk);
      // full init sequence
      foreach (init_seq[i]) send_byte(init_seq[i], 0);
      io_cs = 1;
      check_all("init");
      // contrast and invert
      send_byte(8'h81, 0); send_byte(8'h3C, 0); send_byte(8'hA7, 0);
      check_all("contrast_inv");
      send_byte(8'hA6, 0);
      check_all("inv_clear");
      // partial byte discarded by chip select
      io_cs = 1; repeat (8) @(negedge clk);
      send_bits(8'hFF, 5, 0);
      io_cs = 1; repeat (8) @(negedge clk);
      send_byte(8'h5A, 1);
      io_cs = 1;
      check_all("cs_abort");
      // data byte cancels pending parameter
      send_byte(8'h81, 0); send_byte(8'h99, 1); send_byte(8'hAF, 0);
      check_all("param_abandon");
      // randomized traffic with occasional aborted bytes
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom));
            io_cs = 1;
            repeat (8) @(negedge clk);
         end else if ($urandom_range(0, 1) == 0)
            send_byte(8'($urandom), 1);
         else
            send_byte($urandom_range(0, 2) == 0 ? 8'($urandom) : ops[$urandom_range(0, 9)], 0);
      end
      io_cs = 1;
      check_all("random");
      // display reset after some data
      send_byte(8'h55, 0); send_byte(8'hAF, 0); send_byte(8'hA7, 0);
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
      check_all("pre_ioreset");
      io_reset = 0;
      repeat (10) @(negedge clk);
      io_reset = 1;
      model_reset();
      repeat (6) @(negedge clk);
      check_all("ioreset");
      send_byte(8'hC3, 1);
      io_cs = 1;
      check_all("after_ioreset");
      // rst_n mid-parameter
      send_byte(8'h81, 0);
      send_bits(8'h55, 4, 0);
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      model_reset();
      exp_cmd.delete(); exp_cmd.push_back(8'h81);
      io_cs = 1;
      check_all("rstn_mid_param");
      // full frame plus wrap
      half = 3;
      for (int i = 0; i < 1025; i++) send_byte(8'(i), 1);
      io_cs = 1;
      check_all("frame_wrap");
      chk("both_strobes", both_cnt, 0);
      chk("long_strobe", long_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on each io_* input (legal values 2..3).
REQ-002 clk  input  1  single system clock; all logic is on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 io_sclk  input  1  serial clock from the display driver; idles high; data is sampled on its rising edge.
REQ-005 io_sdin  input  1  serial data, sent MSB first.
REQ-006 io_cs  input  1  chip select, active-low.
REQ-007 io_dc  input  1  0 = command byte, 1 = pixel data byte; sampled with the 8th bit.
REQ-008 io_reset  input  1  display reset, active-low.
REQ-009 fb_we  output  1  one-cycle frame-buffer write strobe.
REQ-010 fb_addr  output  10  frame-buffer byte address, 0..1023.
REQ-011 fb_data  output  8  frame-buffer write data.
REQ-012 cmd_valid  output  1  one-cycle strobe per received command or parameter byte.
REQ-013 cmd_byte  output  8  the byte that goes with cmd_valid.
REQ-014 display_on  output  1  set by 0xAF, cleared by 0xAE.
REQ-015 invert  output  1  set by 0xA7, cleared by 0xA6.
REQ-016 contrast  output  8  parameter of the most recent 0x81 command.
REQ-017 charge_pump  output  1  equals bit 2 of the most recent 0x8D parameter.

Function
REQ-018 All io_* inputs shall pass through SYNC_STAGES flops before use; the block requires clk >= 4x the io_sclk toggle rate.
REQ-019 Byte assembler: a shift event is a synchronized 0->1 transition of io_sclk while synchronized io_cs = 0; each shift event shifts in io_sdin and increments a 3-bit bit counter.
REQ-020 On the 8th shift event the assembler shall complete a byte, tagged with synchronized io_dc, and reset the bit counter to 0; results are registered 1 cycle after the cycle in which the edge is detected.
REQ-021 Synchronized io_cs = 1 shall clear the bit counter; a partial byte is discarded with no strobe.
REQ-022 Command decoder FSM states: CMD_IDLE and CMD_PARAM; it records the pending opcode.
REQ-023 In CMD_IDLE, a dc=0 byte shall pulse cmd_valid.
REQ-024 In CMD_IDLE, opcodes 0x81, 0x20, 0xA8, 0xD3, 0xD5, 0xD9, 0xDB and 0x8D shall move the FSM to CMD_PARAM.
REQ-025 In CMD_IDLE, the opcodes 0xAE, 0xAF, 0xA6 and 0xA7 shall update their flags on the same cycle as cmd_valid.
REQ-026 In CMD_IDLE, all other dc=0 bytes shall be strobed out only, with no state change.
REQ-027 In CMD_PARAM, the next dc=0 byte shall be taken as the parameter: pulse cmd_valid, apply it to contrast (0x81) or charge_pump (0x8D), and return to CMD_IDLE.
REQ-028 A dc=1 byte shall write fb_data at fb_addr with fb_we high for 1 cycle, after which fb_addr increments.
REQ-029 fb_addr shall wrap from 1023 to 0 (horizontal addressing, 128x8 pages).
REQ-030 A dc=1 byte received while in CMD_PARAM shall abandon the pending parameter, return the FSM to CMD_IDLE, and still be written.
REQ-031 fb_we and cmd_valid shall never be high on the same cycle, and neither shall stay high for more than 1 cycle per byte.
REQ-032 Synchronized io_reset = 0 shall apply the same state as REQ-033 to everything except the synchronizers, which keep running; bytes in progress are lost.

Reset
REQ-033 With rst_n = 0 on a clk edge, these outputs and state shall take these values:
- fb_we = 0, cmd_valid = 0, fb_addr = 0, fb_data = 0, cmd_byte = 0
- display_on = 0, invert = 0, contrast = 0x7F, charge_pump = 0
- FSM in CMD_IDLE, bit counter = 0, shift register = 0
- synchronizer flops to io_sclk = 1, io_cs = 1, io_dc = 1, io_reset = 1
REQ-034 Reset asserted mid-byte or mid-parameter shall discard the partial byte or parameter; there is no strobe during reset or on the cycle it is released.

Verification
REQ-035 Full 23-byte SSD1306 init sequence (AE 81 7F A6 20 00 C8 40 A1 A8 3F D3 00 D5 80 D9 22 DB 20 8D 14 A4 AF) sent at clk/8 -> exactly 23 cmd_valid pulses in order; final state display_on = 1, contrast = 0x7F, charge_pump = 1, fb_we never high.
REQ-036 0x81 0x3C then 0xA7 -> contrast = 0x3C, invert = 1; then 0xA6 -> invert = 0.
REQ-037 1025 data bytes with value = index[7:0] -> addresses 0..1023 written in order; the 1025th byte (0x00) written at address 0.
REQ-038 Five bits of 0xFF, then io_cs high, then 0x5A with dc = 1 -> single fb_we with fb_data = 0x5A at address 0.
REQ-039 0x81 (dc = 0) followed by 0x99 (dc = 1), then 0xAF -> 0x99 written to the frame buffer, contrast unchanged at 0x7F, and 0xAF taken as an opcode, giving display_on = 1.
REQ-040 io_reset pulsed low for 10 clk after 3 data bytes -> fb_addr = 0 and flags at reset values; the next data byte is written at address 0.
